// File: rtl/wrr_pkg.sv
// Shared types, defaults and helpers for the weighted round-robin scheduler.
// Holds the FSM state enum and the quantum clamp used at arbitration time.
package wrr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        HOLD,
        GAP
    } state_t;

    localparam int N_DEF        = 8;
    localparam int WW_DEF       = 4;
    localparam int MAX_HOLD_DEF = 15;

    // A zero weight still earns one cycle; oversize weights saturate.
    function automatic int unsigned clamp_quantum(
        input int unsigned w,
        input int unsigned max_hold
    );
        if (w == 0) return 1;
        if (w > max_hold) return max_hold;
        return w;
    endfunction

endpackage

// File: rtl/wrr_grant_scheduler_if.sv
// Request/grant bundle between the requesters and the WRR scheduler.
// master: request, weight, done out; grant, grant_id, busy, hold_cnt in.
interface wrr_grant_scheduler_if #(
    parameter int N  = wrr_pkg::N_DEF,
    parameter int WW = wrr_pkg::WW_DEF
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    request;
    logic [N*WW-1:0] weight;
    logic            done;
    logic [N-1:0]    grant;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic [WW-1:0]   hold_cnt;

    modport master (
        output request, weight, done,
        input  grant, grant_id, busy, hold_cnt
    );

    modport slave (
        input  request, weight, done,
        output grant, grant_id, busy, hold_cnt
    );

endinterface

// File: rtl/wrr_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, mod N.
// Ports: request, ptr in; found, idx out. Purely combinational.
module wrr_rr_pick #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  request,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);
    localparam int W2 = 2 * N;

    logic [W2-1:0] dbl;
    logic [W2-1:0] masked;

    // Lower copy is masked below ptr; the upper copy supplies wrap-around,
    // so the lowest surviving bit is the rotated first match.
    always_comb begin
        dbl    = {request, request};
        masked = dbl & ~((W2'(1) << ptr) - W2'(1));
        found  = |request;
        idx    = '0;
        for (int i = W2 - 1; i >= 0; i--) begin
            if (masked[i]) idx = (i >= N) ? IW'(i - N) : IW'(i);
        end
    end

endmodule

// File: rtl/wrr_grant_scheduler.sv
// Weighted round-robin grant sequencer: IDLE -> ARB -> HOLD -> GAP.
// Ports: clk, reset (async, active-low), bus (slave side of the WRR bundle).
module wrr_grant_scheduler
    import wrr_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int WW       = WW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input logic             clk,
    input logic             reset,
    wrr_grant_scheduler_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_id;
    logic [WW-1:0] q;
    logic [WW-1:0] hold_cnt;
    logic [N-1:0]  grant;
    logic          busy;

    logic          found;
    logic [IW-1:0] pick;
    logic [WW-1:0] w_pick;
    logic          hold_exit;
    logic [IW-1:0] ptr_nxt;

    wrr_rr_pick #(.N(N), .IW(IW)) u_pick (
        .request(bus.request),
        .ptr    (ptr),
        .found  (found),
        .idx    (pick)
    );

    assign w_pick    = bus.weight[int'(pick)*WW +: WW];
    assign hold_exit = (hold_cnt == q) || bus.done
                     || !bus.request[grant_id];
    assign ptr_nxt   = (grant_id == IW'(N - 1)) ? '0
                     : grant_id + IW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            q        <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|bus.request) begin
                        state <= ARB;
                        busy  <= 1'b1;
                    end
                end
                ARB: begin
                    if (found) begin
                        grant_id <= pick;
                        q        <= WW'(clamp_quantum(32'(w_pick),
                                                      32'(MAX_HOLD)));
                        grant    <= N'(1) << pick;
                        hold_cnt <= WW'(1);
                        state    <= HOLD;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_exit) begin
                        grant    <= '0;
                        hold_cnt <= '0;
                        ptr      <= ptr_nxt;
                        state    <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt + WW'(1);
                    end
                end
                GAP: begin
                    if (|bus.request) begin
                        state <= ARB;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant    = grant;
    assign bus.grant_id = grant_id;
    assign bus.busy     = busy;
    assign bus.hold_cnt = hold_cnt;

    a_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(grant));
    a_hold_only: assert property (@(posedge clk) disable iff (!reset)
        (grant == '0) || (state == HOLD));

endmodule

// File: tb/tb_wrr_grant_scheduler.sv
// Directed bench for wrr_grant_scheduler with hand-computed expectations.
// Drives and samples on the falling clock edge.
module tb_wrr_grant_scheduler;

    logic clk;
    logic reset;
    int   n_run  = 0;
    int   n_fail = 0;

    wrr_grant_scheduler_if #(.N(8), .WW(4)) bus ();

    wrr_grant_scheduler #(.N(8), .WW(4), .MAX_HOLD(15)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [7:0] req, input logic [31:0] w);
        @(negedge clk);
        reset       = 1'b0;
        bus.request = req;
        bus.weight  = w;
        bus.done    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [7:0] exp_g [12];
    logic [3:0] exp_h [12];
    int         cnt;
    int         hmax;

    initial begin
        exp_g = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00,
                  8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h04};
        exp_h = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0,
                  4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd1};

        reset       = 1'b0;
        bus.request = '0;
        bus.weight  = '0;
        bus.done    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_id", 32'(bus.grant_id), 32'h0);
        check("rst_hcnt", 32'(bus.hold_cnt), 32'h0);

        // lone requester 2, quantum 3: period of 5
        bus.request = 8'h04;
        bus.weight  = 32'h0000_0300;
        reset       = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("lone_g%0d", i), 32'(bus.grant), 32'(exp_g[i]));
            check($sformatf("lone_h%0d", i), 32'(bus.hold_cnt),
                  32'(exp_h[i]));
        end
        check("lone_id", 32'(bus.grant_id), 32'h2);

        // async reset mid-HOLD, no clock edge in between
        #2 reset = 1'b0;
        #1;
        check("arst_grant", 32'(bus.grant), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_id", 32'(bus.grant_id), 32'h0);
        check("arst_hcnt", 32'(bus.hold_cnt), 32'h0);

        // all requesting, weight 2 each: strict rotation from ptr=0
        @(negedge clk);
        bus.request = 8'hFF;
        bus.weight  = 32'h2222_2222;
        reset       = 1'b1;
        @(negedge clk);
        check("rr_arb_busy", 32'(bus.busy), 32'h1);
        check("rr_arb_g", 32'(bus.grant), 32'h0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("rr_g%0d", k), 32'(bus.grant),
                  32'(8'h01 << (k % 8)));
            check($sformatf("rr_id%0d", k), 32'(bus.grant_id), 32'(k % 8));
            @(negedge clk);
            check($sformatf("rr_h%0d", k), 32'(bus.hold_cnt), 32'h2);
            @(negedge clk);
            check($sformatf("rr_gap%0d", k), 32'(bus.grant), 32'h0);
            @(negedge clk);
            check($sformatf("rr_arb%0d", k), 32'(bus.grant), 32'h0);
        end

        // weight 0 -> 1 cycle, weight F -> 15 cycles
        do_reset(8'h03, 32'h0000_00F0);
        @(negedge clk);
        check("clamp_arb", 32'(bus.grant), 32'h0);
        @(negedge clk);
        check("clamp_g0", 32'(bus.grant), 32'h01);
        @(negedge clk);
        check("clamp_gap0", 32'(bus.grant), 32'h0);
        @(negedge clk);
        cnt  = 0;
        hmax = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.grant == 8'h02) cnt++;
            if (int'(bus.hold_cnt) > hmax) hmax = int'(bus.hold_cnt);
        end
        check("clamp_len1", 32'(cnt), 32'd15);
        check("clamp_hmax", 32'(hmax), 32'd15);
        check("clamp_gap1", 32'(bus.grant), 32'h0);
        repeat (2) @(negedge clk);
        check("clamp_wrap", 32'(bus.grant), 32'h01);

        // early release with done
        do_reset(8'h01, 32'h0000_0025);
        @(negedge clk);
        @(negedge clk);
        check("done_g", 32'(bus.grant), 32'h01);
        @(negedge clk);
        check("done_h2", 32'(bus.hold_cnt), 32'h2);
        bus.done = 1'b1;
        @(negedge clk);
        check("done_drop", 32'(bus.grant), 32'h0);
        check("done_hclr", 32'(bus.hold_cnt), 32'h0);
        bus.done    = 1'b0;
        bus.request = 8'h03;
        @(negedge clk);
        check("done_arb", 32'(bus.grant), 32'h0);
        @(negedge clk);
        check("done_ptr", 32'(bus.grant), 32'h02);
        @(negedge clk);
        check("both_h2", 32'(bus.hold_cnt), 32'h2);
        bus.done = 1'b1;
        @(negedge clk);
        check("both_gap", 32'(bus.grant), 32'h0);
        bus.done = 1'b0;
        @(negedge clk);
        check("both_arb", 32'(bus.grant), 32'h0);
        @(negedge clk);
        check("both_next", 32'(bus.grant), 32'h01);

        // grantee drops request; weight change mid-HOLD ignored
        do_reset(8'h03, 32'h0000_0044);
        @(negedge clk);
        @(negedge clk);
        check("drop_g0", 32'(bus.grant), 32'h01);
        @(negedge clk);
        bus.request = 8'h02;
        @(negedge clk);
        check("drop_gap", 32'(bus.grant), 32'h0);
        @(negedge clk);
        check("drop_arb", 32'(bus.grant), 32'h0);
        @(negedge clk);
        check("drop_g1", 32'(bus.grant), 32'h02);
        check("drop_id", 32'(bus.grant_id), 32'h1);
        bus.weight = 32'h0000_0024;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("wchg_g%0d", i), 32'(bus.grant), 32'h02);
        end
        check("wchg_h4", 32'(bus.hold_cnt), 32'h4);
        @(negedge clk);
        check("wchg_gap", 32'(bus.grant), 32'h0);

        // done outside HOLD has no effect
        bus.weight = 32'h0000_0044;
        bus.done   = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        @(negedge clk);
        check("idle_done_g", 32'(bus.grant), 32'h02);
        @(negedge clk);
        check("idle_done_h", 32'(bus.hold_cnt), 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
